regfile_wport_arbiter: RTL

- Shares the single general-register-file write port (we/waddr/wdata) among three writeback sources:
  - the in-order pipeline writeback stage (port 0);
  - the multi-cycle mul/div unit (port 1);
  - the load-return path (port 2).
- Port 0 has fixed priority. Ports 1 and 2 share the remaining slots round-robin.
- A starvation counter forces a pipeline stall so that a long-waiting port 1/2 result gets a slot.
- Sits between the writeback stage and the register file. The write port it drives is registered.

---
 rtl/regfile_wport_arbiter_if.sv | 32 +++
 rtl/regfile_wport_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - writeback source and register-file write port bundle
interface regfile_wport_arbiter_if;
  logic        p0_we;
  logic [4:0]  p0_waddr;
  logic [31:0] p0_wdata;
  logic        p1_valid;
  logic [4:0]  p1_waddr;
  logic [31:0] p1_wdata;
  logic        p1_ready;
  logic        p2_valid;
  logic [4:0]  p2_waddr;
  logic [31:0] p2_wdata;
  logic        p2_ready;
  logic        stall_req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output p0_we, p0_waddr, p0_wdata,
    output p1_valid, p1_waddr, p1_wdata,
    output p2_valid, p2_waddr, p2_wdata,
    input  p1_ready, p2_ready, stall_req, we, waddr, wdata
  );

  modport slave (
    input  p0_we, p0_waddr, p0_wdata,
    input  p1_valid, p1_waddr, p1_wdata,
    input  p2_valid, p2_waddr, p2_wdata,
    output p1_ready, p2_ready, stall_req, we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register-file write port arbiter: fixed-priority pipeline, round-robin mul/div and load
module regfile_wport_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wport_arbiter_if.slave  bus
);

  typedef enum logic {RR_P1 = 1'b0, RR_P2 = 1'b1} rr_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  rr_t             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stall_q, stall_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic p0_write, slot_free, contested, grant1, grant2, blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= RR_P1;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    p0_write  = bus.p0_we && (bus.p0_waddr != 5'd0);
    slot_free = !p0_write;
    contested = slot_free && bus.p1_valid && bus.p2_valid;
    grant1    = !rst && slot_free && bus.p1_valid && (!bus.p2_valid || rr_q == RR_P1);
    grant2    = !rst && slot_free && bus.p2_valid && (!bus.p1_valid || rr_q == RR_P2);
    blocked   = (bus.p1_valid || bus.p2_valid) && !grant1 && !grant2;

    rr_d = rr_q;
    if (contested) begin
      rr_d = (rr_q == RR_P1) ? RR_P2 : RR_P1;
    end

    // Grant or no request both clear the counter; saturate rather than wrap.
    cnt_d = '0;
    if (blocked) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    stall_d = stall_q;
    if (grant1 || grant2) begin
      stall_d = 1'b0;
    end else if (blocked && cnt_q >= LIMIT_M1) begin
      stall_d = 1'b1;
    end

    // Writes to $0 from any source are accepted but never reach the register file.
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (p0_write) begin
      we_d    = 1'b1;
      waddr_d = bus.p0_waddr;
      wdata_d = bus.p0_wdata;
    end else if (grant1 && bus.p1_waddr != 5'd0) begin
      we_d    = 1'b1;
      waddr_d = bus.p1_waddr;
      wdata_d = bus.p1_wdata;
    end else if (grant2 && bus.p2_waddr != 5'd0) begin
      we_d    = 1'b1;
      waddr_d = bus.p2_waddr;
      wdata_d = bus.p2_wdata;
    end
  end

  assign bus.p1_ready  = grant1;
  assign bus.p2_ready  = grant2;
  assign bus.stall_req = stall_q;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

endmodule
